// File: rtl/ula_dr_pkg.sv
// rtl/ula_dr_pkg.sv - rail codes, widths and shared types for the NCL ULA result capture
package ula_dr_pkg;

    localparam logic [1:0] DR_ONE  = 2'b10;
    localparam logic [1:0] DR_ZERO = 2'b01;
    localparam logic [1:0] DR_NULL = 2'b00;

    localparam int ULA_DR_WIDTH = 16;
    localparam int ULA_BITS     = 5;
    localparam int ULA_PAIRS    = ULA_DR_WIDTH / 2;

    typedef enum logic [1:0] {
        WAIT_NULL,
        WAIT_DATA,
        PUSH
    } capture_state_e;

    typedef struct packed {
        logic [ULA_BITS-1:0] data;
        logic                ovf;
        logic                neg;
        logic                zero;
    } ula_result_t;

    function automatic logic dr_is_data(input logic [1:0] pair);
        return (pair == DR_ONE) || (pair == DR_ZERO);
    endfunction

endpackage

// File: rtl/ula_result_capture_if.sv
// rtl/ula_result_capture_if.sv - dual-rail ULA outputs, NCL acknowledge and decoded result stream
interface ula_result_capture_if;
    import ula_dr_pkg::*;

    logic [2*ULA_BITS-1:0] Out;
    logic [1:0]            Overflow;
    logic [1:0]            Neg;
    logic [1:0]            Zero;
    logic                  Ko;
    logic                  ResValid;
    logic                  ResReady;
    logic [ULA_BITS-1:0]   ResData;
    logic                  ResOverflow;
    logic                  ResNeg;
    logic                  ResZero;
    logic                  CodeError;
    logic                  Timeout;
    logic                  ErrClr;

    // slave is the capture block; master is the ULA plus the result consumer
    modport slave (
        input  Out, Overflow, Neg, Zero, ResReady, ErrClr,
        output Ko, ResValid, ResData, ResOverflow, ResNeg, ResZero, CodeError, Timeout
    );

    modport master (
        output Out, Overflow, Neg, Zero, ResReady, ErrClr,
        input  Ko, ResValid, ResData, ResOverflow, ResNeg, ResZero, CodeError, Timeout
    );

endinterface

// File: rtl/ula_result_fifo.sv
// rtl/ula_result_fifo.sv - synchronous valid/ready FIFO, power-of-two depth
module ula_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_s_tvalid,
    output logic             o_s_tready,
    input  logic [WIDTH-1:0] i_s_tdata,
    output logic             o_m_tvalid,
    input  logic             i_m_tready,
    output logic [WIDTH-1:0] o_m_tdata
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_wr;
    logic w_rd;

    assign w_full     = (r_count == CNT_FULL);
    assign o_m_tvalid = (r_count != '0);
    assign w_rd       = o_m_tvalid && i_m_tready;
    // A read in the same cycle frees the slot, so a full FIFO still accepts a write
    assign o_s_tready = !w_full || w_rd;
    assign w_wr       = i_s_tvalid && o_s_tready;
    assign o_m_tdata  = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_s_tdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ula_result_capture.sv
// rtl/ula_result_capture.sv - samples dual-rail ULA outputs, runs the NCL handshake and queues decoded results
module ula_result_capture
    import ula_dr_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 2,
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                Clk,
    input  logic                Rst,
    ula_result_capture_if.slave bus
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_THR = STAB_W'(STABLE_CYCLES - 1);

    localparam int WARM_CYCLES = SYNC_STAGES + 1;
    localparam int WARM_W      = $clog2(WARM_CYCLES + 1);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(WARM_CYCLES);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [ULA_DR_WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [ULA_DR_WIDTH-1:0] r_prev;
    logic [STAB_W-1:0]       r_stab;
    logic [WARM_W-1:0]       r_warm;
    logic [TO_W-1:0]         r_to;
    capture_state_e          r_state;
    ula_result_t             r_result;
    logic                    r_code_err;
    logic                    r_timeout;

    logic [ULA_DR_WIDTH-1:0] w_rails;
    logic [ULA_DR_WIDTH-1:0] w_sync;
    logic [STAB_W-1:0]       w_stab_next;
    logic                    w_warm;
    logic                    w_stable;
    logic                    w_all_data;
    logic                    w_all_null;
    logic                    w_illegal;
    ula_result_t             w_decoded;
    ula_result_t             w_head;
    capture_state_e          w_state_next;
    logic                    w_ko;
    logic                    w_ko_next;
    logic                    w_push;
    logic                    w_capture;
    logic                    w_code_err_set;
    logic                    w_to_run;
    logic                    w_to_set;
    logic                    w_fifo_ready;
    logic                    w_fifo_valid;

    assign w_rails = {bus.Zero, bus.Neg, bus.Overflow, bus.Out};
    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign w_warm  = (r_warm == WARM_DONE);

    // Synchronizer chain plus stability tracking. Until the chain has refilled
    // with real samples after reset, nothing is considered stable.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
            r_stab <= '0;
            r_warm <= '0;
        end else begin
            r_sync[0] <= w_rails;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync;
            if (!w_warm) begin
                r_warm <= r_warm + 1'b1;
            end
            r_stab <= (w_ko_next != w_ko) ? '0 : w_stab_next;
        end
    end

    always_comb begin
        w_stab_next = '0;
        if (w_warm && (w_sync == r_prev)) begin
            w_stab_next = (r_stab == STAB_MAX) ? r_stab : r_stab + 1'b1;
        end
    end

    assign w_stable = w_warm && (w_stab_next >= STAB_THR);

    always_comb begin
        w_all_data = 1'b1;
        w_all_null = 1'b1;
        w_illegal  = 1'b0;
        for (int p = 0; p < ULA_PAIRS; p++) begin
            w_all_data = w_all_data & dr_is_data(w_sync[2*p +: 2]);
            w_all_null = w_all_null & (w_sync[2*p +: 2] == DR_NULL);
            w_illegal  = w_illegal  | (&w_sync[2*p +: 2]);
        end
    end

    // The TRUE rail of a complete pair is the single-rail value
    always_comb begin
        w_decoded = '0;
        for (int i = 0; i < ULA_BITS; i++) begin
            w_decoded.data[i] = w_sync[2*i+1];
        end
        w_decoded.ovf  = w_sync[2*ULA_BITS+1];
        w_decoded.neg  = w_sync[2*ULA_BITS+3];
        w_decoded.zero = w_sync[2*ULA_BITS+5];
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= WAIT_NULL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_push         = 1'b0;
        w_capture      = 1'b0;
        w_code_err_set = 1'b0;
        w_ko           = (r_state != WAIT_NULL);
        case (r_state)
            WAIT_NULL: begin
                if (w_stable && w_all_null) begin
                    w_state_next = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (w_stable && w_all_data) begin
                    w_capture    = 1'b1;
                    w_state_next = PUSH;
                end else if (w_stable && w_illegal) begin
                    w_code_err_set = 1'b1;
                    w_state_next   = WAIT_NULL;
                end
            end
            PUSH: begin
                if (w_fifo_ready) begin
                    w_push       = 1'b1;
                    w_state_next = WAIT_NULL;
                end
            end
            default: begin
                w_state_next = WAIT_NULL;
            end
        endcase
    end

    assign w_ko_next = (w_state_next != WAIT_NULL);

    assign w_to_run = (r_state != PUSH) && (w_state_next == r_state);
    assign w_to_set = w_to_run && (r_to == TO_LAST);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_to       <= '0;
            r_result   <= '0;
            r_code_err <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (!w_to_run) begin
                r_to <= '0;
            end else if (r_to != TO_MAX) begin
                r_to <= r_to + 1'b1;
            end
            if (w_capture) begin
                r_result <= w_decoded;
            end
            // A set in the same cycle as ErrClr wins
            if (w_code_err_set) begin
                r_code_err <= 1'b1;
            end else if (bus.ErrClr) begin
                r_code_err <= 1'b0;
            end
            if (w_to_set) begin
                r_timeout <= 1'b1;
            end else if (bus.ErrClr) begin
                r_timeout <= 1'b0;
            end
        end
    end

    ula_result_fifo #(
        .WIDTH ($bits(ula_result_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (Clk),
        .i_rst      (Rst),
        .i_s_tvalid (w_push),
        .o_s_tready (w_fifo_ready),
        .i_s_tdata  (r_result),
        .o_m_tvalid (w_fifo_valid),
        .i_m_tready (bus.ResReady),
        .o_m_tdata  (w_head)
    );

    assign bus.Ko          = w_ko;
    assign bus.ResValid    = w_fifo_valid;
    assign bus.ResData     = w_head.data;
    assign bus.ResOverflow = w_head.ovf;
    assign bus.ResNeg      = w_head.neg;
    assign bus.ResZero     = w_head.zero;
    assign bus.CodeError   = r_code_err;
    assign bus.Timeout     = r_timeout;

endmodule

// File: tb/tb_ula_result_capture.sv
// tb/tb_ula_result_capture.sv - directed/random bench for ula_result_capture against a queue model
module tb_ula_result_capture;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [7:0] exp_q [$];

    ula_result_capture_if bus();

    ula_result_capture #(
        .SYNC_STAGES    (2),
        .STABLE_CYCLES  (2),
        .FIFO_DEPTH     (2),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Result layout {data[4:0], ovf, neg, zero}; rails {Zero, Neg, Overflow, Out}
    function automatic logic [15:0] enc(input logic [7:0] r);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 5; i++) begin
            w[2*i +: 2] = r[3+i] ? 2'b10 : 2'b01;
        end
        w[11:10] = r[2] ? 2'b10 : 2'b01;
        w[13:12] = r[1] ? 2'b10 : 2'b01;
        w[15:14] = r[0] ? 2'b10 : 2'b01;
        return w;
    endfunction

    function automatic logic [7:0] head();
        return {bus.ResData, bus.ResOverflow, bus.ResNeg, bus.ResZero};
    endfunction

    task automatic drive(input logic [15:0] w);
        bus.Out      = w[9:0];
        bus.Overflow = w[11:10];
        bus.Neg      = w[13:12];
        bus.Zero     = w[15:14];
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ko(input logic val, input string tag);
        int n;
        n = 0;
        while (bus.Ko !== val && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, bus.Ko, val);
    endtask

    task automatic pop_check(input string tag);
        int n;
        logic [7:0] e;
        n = 0;
        e = 8'h00;
        while (bus.ResValid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, bus.ResValid, 1'b1);
        chk({tag, "_model_nonempty"}, exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
        end
        chk(tag, head(), e);
        bus.ResReady = 1'b1;
        @(negedge clk);
        bus.ResReady = 1'b0;
    endtask

    initial begin : stim
        logic [7:0]  v;
        logic [15:0] w;

        rst          = 1'b1;
        bus.ErrClr   = 1'b0;
        bus.ResReady = 1'b0;
        drive(16'h0000);
        tick(3);
        chk("rst_ko", bus.Ko, 1'b0);
        chk("rst_valid", bus.ResValid, 1'b0);
        chk("rst_head", head(), 8'h00);
        chk("rst_codeerr", bus.CodeError, 1'b0);
        chk("rst_timeout", bus.Timeout, 1'b0);
        rst = 1'b0;
        tick(1);
        chk("null_ko_low", bus.Ko, 1'b0);
        wait_ko(1'b1, "null_ko_rise");

        // Fixed wavefront: data 10110, ovf 0, neg 1, zero 0
        drive({2'b01, 2'b10, 2'b01, 10'b10_01_10_10_01});
        exp_q.push_back(8'b10110_0_1_0);
        tick(4);
        chk("lat_not_yet", bus.ResValid, 1'b0);
        tick(1);
        chk("lat_valid", bus.ResValid, 1'b1);
        chk("lat_ko_drop", bus.Ko, 1'b0);
        tick(2);
        chk("hold_head", head(), 8'b10110_0_1_0);
        pop_check("first");
        chk("first_empty", bus.ResValid, 1'b0);

        // Skewed arrival: flags first, then one Out pair per cycle
        drive(16'h0000);
        wait_ko(1'b1, "skew_ko");
        v = 8'($urandom);
        w = 16'h0000;
        w[15:10] = enc(v) >> 10;
        drive(w);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            w[2*i +: 2] = enc(v) >> (2*i);
            drive(w);
            tick(1);
            chk("skew_partial", bus.ResValid, 1'b0);
        end
        exp_q.push_back(v);
        tick(3);
        chk("skew_not_yet", bus.ResValid, 1'b0);
        tick(1);
        chk("skew_valid", bus.ResValid, 1'b1);
        pop_check("skew");
        chk("skew_single", bus.ResValid, 1'b0);

        // Backpressure: three wavefronts into a 2-deep FIFO with no reader
        drive(16'h0000);
        wait_ko(1'b1, "bp_ko_start");
        for (int k = 0; k < 3; k++) begin
            v = 8'($urandom);
            drive(enc(v));
            exp_q.push_back(v);
            if (k < 2) begin
                wait_ko(1'b0, "bp_ko_ack");
                drive(16'h0000);
                wait_ko(1'b1, "bp_ko_req");
            end
        end
        tick(20);
        chk("bp_hold_ko", bus.Ko, 1'b1);
        chk("bp_hold_valid", bus.ResValid, 1'b1);
        pop_check("bp0");
        chk("bp_ko_release", bus.Ko, 1'b0);
        pop_check("bp1");
        pop_check("bp2");
        chk("bp_drained", bus.ResValid, 1'b0);

        // Illegal pair on Zero
        drive(16'h0000);
        wait_ko(1'b1, "ill_ko");
        w = enc(8'($urandom));
        w[15:14] = 2'b11;
        drive(w);
        tick(6);
        chk("ill_codeerr", bus.CodeError, 1'b1);
        chk("ill_ko", bus.Ko, 1'b0);
        chk("ill_nopush", bus.ResValid, 1'b0);
        bus.ErrClr = 1'b1;
        tick(1);
        bus.ErrClr = 1'b0;
        chk("ill_clr", bus.CodeError, 1'b0);

        // Timeout in WAIT_DATA, then normal capture still works
        drive(16'h0000);
        wait_ko(1'b1, "to_ko");
        tick(1023);
        chk("to_before", bus.Timeout, 1'b0);
        tick(1);
        chk("to_set", bus.Timeout, 1'b1);
        v = 8'($urandom);
        drive(enc(v));
        exp_q.push_back(v);
        tick(5);
        chk("to_capture_valid", bus.ResValid, 1'b1);
        chk("to_sticky", bus.Timeout, 1'b1);
        pop_check("to_capture");
        drive(16'h0000);
        bus.ErrClr = 1'b1;
        tick(1);
        bus.ErrClr = 1'b0;
        chk("to_clr", bus.Timeout, 1'b0);

        // Reset while in PUSH with one entry queued
        wait_ko(1'b1, "rs_ko1");
        v = 8'($urandom);
        drive(enc(v));
        exp_q.push_back(v);
        wait_ko(1'b0, "rs_ack1");
        drive(16'h0000);
        wait_ko(1'b1, "rs_ko2");
        drive(enc(8'($urandom)));
        tick(4);
        chk("rs_in_push_ko", bus.Ko, 1'b1);
        chk("rs_in_push_valid", bus.ResValid, 1'b1);
        rst = 1'b1;
        #1;
        chk("rs_async_valid", bus.ResValid, 1'b0);
        chk("rs_async_ko", bus.Ko, 1'b0);
        chk("rs_async_head", head(), 8'h00);
        exp_q.delete();
        tick(1);
        rst = 1'b0;
        tick(30);
        chk("rs_data_ignored_ko", bus.Ko, 1'b0);
        chk("rs_data_ignored_valid", bus.ResValid, 1'b0);
        drive(16'h0000);
        wait_ko(1'b1, "rs_null_ko");
        v = 8'($urandom);
        drive(enc(v));
        exp_q.push_back(v);
        tick(5);
        pop_check("rs_after");
        chk("final_empty", bus.ResValid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
